mult_share_arb: RTL and testbench

Round-robin arbiter and two-stage pipeline that shares a single unsigned 16x16 multiplier among NREQ requesters. It sits between several client blocks (filters, address generators, lab datapaths) and one multiplier instance. Each cycle it accepts at most one operand pair, tags it with the requester index, and returns the 32-bit product two cycles later on a shared response bus.

---
 rtl/mult_share_arb.sv | 107 ++++++++++
 tb/tb_mult_share_arb.sv | 271 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/mult_share_arb.sv
// rtl/mult_share_arb.sv - round-robin arbiter sharing one 16x16 multiplier through a two-stage pipeline
`timescale 1ns/1ps

module mult_share_arb #(
  parameter int NREQ = 4,
  parameter int ID_W = 2
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 en,
  input  logic [NREQ-1:0]      req_valid,
  input  logic [16*NREQ-1:0]   req_a,
  input  logic [16*NREQ-1:0]   req_b,
  output logic [NREQ-1:0]      req_ready,
  output logic                 rsp_valid,
  output logic [ID_W-1:0]      rsp_id,
  output logic [31:0]          rsp_prod,
  output logic                 busy,
  output logic [15:0]          op_count
);

  logic [ID_W-1:0] rr_ptr_q, rr_ptr_d;
  logic            s1_valid_q, s1_valid_d;
  logic [15:0]     s1_a_q, s1_a_d;
  logic [15:0]     s1_b_q, s1_b_d;
  logic [ID_W-1:0] s1_id_q, s1_id_d;
  logic            rsp_valid_q, rsp_valid_d;
  logic [ID_W-1:0] rsp_id_q, rsp_id_d;
  logic [31:0]     rsp_prod_q, rsp_prod_d;
  logic [15:0]     op_count_q, op_count_d;

  logic            grant;
  int              win_idx;

  // Round-robin search from rr_ptr upward with wrap; reset forces no grant
  always_comb begin
    grant     = 1'b0;
    win_idx   = 0;
    req_ready = '0;
    for (int k = 0; k < NREQ; k++) begin
      int idx;
      idx = (int'(rr_ptr_q) + k) % NREQ;
      if (!grant && en && !rst && req_valid[idx]) begin
        grant     = 1'b1;
        win_idx   = idx;
        req_ready = NREQ'(1) << idx;
      end
    end
  end

  // Next-state for pointer, stage 1 capture, stage 2 multiply and counter
  always_comb begin
    rr_ptr_d    = rr_ptr_q;
    s1_valid_d  = grant;
    s1_a_d      = s1_a_q;
    s1_b_d      = s1_b_q;
    s1_id_d     = s1_id_q;
    op_count_d  = op_count_q;
    if (grant) begin
      s1_a_d     = req_a[16*win_idx +: 16];
      s1_b_d     = req_b[16*win_idx +: 16];
      s1_id_d    = ID_W'(win_idx);
      rr_ptr_d   = (win_idx + 1 == NREQ) ? '0 : ID_W'(win_idx + 1);
      op_count_d = op_count_q + 16'd1;
    end
    rsp_valid_d = s1_valid_q;
    rsp_id_d    = rsp_id_q;
    rsp_prod_d  = rsp_prod_q;
    // Response registers hold their last value between pulses
    if (s1_valid_q) begin
      rsp_id_d   = s1_id_q;
      rsp_prod_d = {16'd0, s1_a_q} * {16'd0, s1_b_q};
    end
  end

  // All state registers; reset discards any in-flight operation
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rr_ptr_q    <= '0;
      s1_valid_q  <= 1'b0;
      s1_a_q      <= '0;
      s1_b_q      <= '0;
      s1_id_q     <= '0;
      rsp_valid_q <= 1'b0;
      rsp_id_q    <= '0;
      rsp_prod_q  <= '0;
      op_count_q  <= '0;
    end else begin
      rr_ptr_q    <= rr_ptr_d;
      s1_valid_q  <= s1_valid_d;
      s1_a_q      <= s1_a_d;
      s1_b_q      <= s1_b_d;
      s1_id_q     <= s1_id_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_id_q    <= rsp_id_d;
      rsp_prod_q  <= rsp_prod_d;
      op_count_q  <= op_count_d;
    end
  end

  assign rsp_valid = rsp_valid_q;
  assign rsp_id    = rsp_id_q;
  assign rsp_prod  = rsp_prod_q;
  assign busy      = s1_valid_q | rsp_valid_q;
  assign op_count  = op_count_q;

endmodule

// File: tb/tb_mult_share_arb.sv
// tb/tb_mult_share_arb.sv - randomized and directed self-checking bench for mult_share_arb
`timescale 1ns/1ps

module tb_mult_share_arb;
  localparam int NREQ = 4;
  localparam int ID_W = 2;

  logic                clk = 1'b0;
  logic                rst = 1'b1;
  logic                en = 1'b0;
  logic [NREQ-1:0]     req_valid = '0;
  logic [16*NREQ-1:0]  req_a = '0;
  logic [16*NREQ-1:0]  req_b = '0;
  logic [NREQ-1:0]     req_ready;
  logic                rsp_valid;
  logic [ID_W-1:0]     rsp_id;
  logic [31:0]         rsp_prod;
  logic                busy;
  logic [15:0]         op_count;

  mult_share_arb #(.NREQ(NREQ), .ID_W(ID_W)) dut (
    .clk(clk), .rst(rst), .en(en),
    .req_valid(req_valid), .req_a(req_a), .req_b(req_b), .req_ready(req_ready),
    .rsp_valid(rsp_valid), .rsp_id(rsp_id), .rsp_prod(rsp_prod),
    .busy(busy), .op_count(op_count)
  );

  always #5 clk = ~clk;

  typedef struct {
    int          due;
    int          id;
    logic [31:0] prod;
  } rsp_t;

  int          n_tests = 0;
  int          n_fail = 0;
  int          cyc = 0;
  rsp_t        exp_q[$];
  int          m_ptr = 0;
  logic [15:0] m_count = 16'd0;
  int          last_id = 0;
  logic [31:0] last_prod = 32'd0;
  logic        pend_v[NREQ];
  logic [15:0] pend_a[NREQ];
  logic [15:0] pend_b[NREQ];
  logic        refill = 1'b0;
  int          grant_log[$];
  logic [31:0] prod_log[$];
  int          id_log[$];
  logic        busy_log[$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  function automatic logic [15:0] rnd16();
    case ($urandom_range(3))
      0: rnd16 = 16'hFFFF;
      1: rnd16 = 16'(($urandom_range(1) == 0) ? 0 : 1);
      default: rnd16 = 16'($urandom);
    endcase
  endfunction

  function automatic int onehot_idx(input logic [NREQ-1:0] v);
    int r;
    r = -1;
    for (int i = 0; i < NREQ; i++)
      if (v[i]) r = (r == -1) ? i : -2;
    return r;
  endfunction

  task automatic clear_logs();
    grant_log.delete();
    prod_log.delete();
    id_log.delete();
    busy_log.delete();
  endtask

  // One clock cycle: drive, compare against the model, advance the model
  task automatic step();
    int w;
    logic [NREQ-1:0] exp_ready;
    logic ev;
    for (int i = 0; i < NREQ; i++) begin
      req_valid[i]       = pend_v[i];
      req_a[16*i +: 16]  = pend_a[i];
      req_b[16*i +: 16]  = pend_b[i];
    end
    #4;
    w = -1;
    if (en)
      for (int k = 0; k < NREQ; k++)
        if (w < 0 && pend_v[(m_ptr + k) % NREQ]) w = (m_ptr + k) % NREQ;
    exp_ready = (w >= 0) ? NREQ'(1) << w : '0;
    check("req_ready", 32'(req_ready), 32'(exp_ready));
    check("busy", 32'(busy), 32'(exp_q.size() != 0));
    ev = 1'b0;
    if (exp_q.size() != 0 && exp_q[0].due == cyc) begin
      ev = 1'b1;
      last_id   = exp_q[0].id;
      last_prod = exp_q[0].prod;
      void'(exp_q.pop_front());
    end
    check("rsp_valid", 32'(rsp_valid), 32'(ev));
    check("rsp_id", 32'(rsp_id), 32'(last_id));
    check("rsp_prod", rsp_prod, last_prod);
    check("op_count", 32'(op_count), 32'(m_count));
    grant_log.push_back(onehot_idx(req_ready));
    busy_log.push_back(busy);
    if (rsp_valid) begin
      prod_log.push_back(rsp_prod);
      id_log.push_back(int'(rsp_id));
    end
    if (w >= 0) begin
      rsp_t r;
      r.due  = cyc + 2;
      r.id   = w;
      r.prod = 32'(pend_a[w]) * 32'(pend_b[w]);
      exp_q.push_back(r);
      m_ptr   = (w + 1) % NREQ;
      m_count = m_count + 16'd1;
      if (!refill) pend_v[w] = 1'b0;
    end
    @(posedge clk);
    #1;
    cyc++;
  endtask

  // Assert reset from the current point in the cycle and check the cleared state
  task automatic do_reset();
    rst = 1'b1;
    req_valid = '1;
    en = 1'b1;
    #1;
    check("rst_req_ready", 32'(req_ready), 32'd0);
    check("rst_rsp_valid", 32'(rsp_valid), 32'd0);
    check("rst_rsp_id", 32'(rsp_id), 32'd0);
    check("rst_rsp_prod", rsp_prod, 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_op_count", 32'(op_count), 32'd0);
    exp_q.delete();
    m_ptr = 0;
    m_count = 16'd0;
    last_id = 0;
    last_prod = 32'd0;
    for (int i = 0; i < NREQ; i++) pend_v[i] = 1'b0;
    req_valid = '0;
    @(posedge clk);
    @(posedge clk);
    #1;
    rst = 1'b0;
    cyc += 10;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    for (int i = 0; i < NREQ; i++) begin
      pend_v[i] = 1'b0;
      pend_a[i] = 16'd0;
      pend_b[i] = 16'd0;
    end
    @(posedge clk);
    #1;
    do_reset();
    en = 1'b1;

    // Single op from requester 2
    clear_logs();
    pend_v[2] = 1'b1; pend_a[2] = 16'h0003; pend_b[2] = 16'h0005;
    repeat (4) step();
    check("t1_grant", 32'(grant_log[0]), 32'd2);
    check("t1_prod", prod_log.size() == 1 ? prod_log[0] : 32'hDEAD_BEEF, 32'h0000000F);
    check("t1_id", id_log.size() == 1 ? 32'(id_log[0]) : 32'hFFFF, 32'd2);
    check("t1_busy", {28'd0, busy_log[0], busy_log[1], busy_log[2], busy_log[3]}, 32'b0110);
    check("t1_count", 32'(op_count), 32'd1);

    // Max operands from requester 0
    clear_logs();
    pend_v[0] = 1'b1; pend_a[0] = 16'hFFFF; pend_b[0] = 16'hFFFF;
    repeat (3) step();
    check("max_prod", prod_log.size() == 1 ? prod_log[0] : 32'd0, 32'hFFFE0001);

    // Round robin with all requesters continuously valid
    do_reset();
    en = 1'b1;
    clear_logs();
    refill = 1'b1;
    for (int i = 0; i < NREQ; i++) begin
      pend_v[i] = 1'b1; pend_a[i] = 16'(i + 1); pend_b[i] = 16'h0010;
    end
    repeat (8) step();
    refill = 1'b0;
    for (int i = 0; i < NREQ; i++) pend_v[i] = 1'b0;
    repeat (2) step();
    for (int j = 0; j < 8; j++) begin
      check("rr_grant", 32'(grant_log[j]), 32'(j % 4));
      check("rr_prod", prod_log.size() > j ? prod_log[j] : 32'hDEAD_BEEF, 32'((j % 4 + 1) * 16));
    end

    // en gating mid-stream
    clear_logs();
    refill = 1'b1;
    for (int i = 0; i < NREQ; i++) pend_v[i] = 1'b1;
    en = 1'b1;
    repeat (3) step();
    en = 1'b0;
    repeat (3) step();
    en = 1'b1;
    repeat (2) step();
    refill = 1'b0;
    for (int i = 0; i < NREQ; i++) pend_v[i] = 1'b0;
    repeat (2) step();
    begin
      int eg[8];
      logic [31:0] ep[5];
      eg = '{0, 1, 2, -1, -1, -1, 3, 0};
      ep = '{32'h10, 32'h20, 32'h30, 32'h40, 32'h10};
      for (int j = 0; j < 8; j++) check("en_grant", 32'(grant_log[j]), 32'(eg[j]));
      for (int j = 0; j < 5; j++)
        check("en_prod", prod_log.size() > j ? prod_log[j] : 32'hDEAD_BEEF, ep[j]);
    end

    // Randomized traffic with occasional resets
    for (int c = 0; c < 1500; c++) begin
      en = ($urandom_range(7) != 0);
      for (int i = 0; i < NREQ; i++)
        if (!pend_v[i] && $urandom_range(1) == 1) begin
          pend_v[i] = 1'b1; pend_a[i] = rnd16(); pend_b[i] = rnd16();
        end
      if ($urandom_range(399) == 0) do_reset();
      else step();
    end
    en = 1'b1;
    for (int i = 0; i < NREQ; i++) pend_v[i] = 1'b0;
    repeat (3) step();

    // Reset in the cycle after a grant
    clear_logs();
    pend_v[1] = 1'b1; pend_a[1] = 16'h1234; pend_b[1] = 16'h0010;
    step();
    do_reset();
    en = 1'b1;
    repeat (4) step();
    check("midrst_no_stale", 32'(prod_log.size()), 32'd0);

    // Counter wrap with a single requester valid every cycle
    do_reset();
    en = 1'b1;
    refill = 1'b1;
    pend_v[3] = 1'b1; pend_a[3] = 16'h0002; pend_b[3] = 16'h0007;
    repeat (65536) step();
    refill = 1'b0;
    pend_v[3] = 1'b0;
    check("wrap_count", 32'(op_count), 32'd0);
    repeat (3) step();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
